// File: rtl/serial_pkg.sv
// Shared constants for the serial link blocks: receiver state encoding and
// the default word/buffer geometry used by the shift register bench too.
package serial_pkg;

    // Default geometry of one serial frame and of the receive buffer.
    localparam int DEFAULT_DATA_WIDTH = 8;
    localparam int DEFAULT_FIFO_DEPTH = 4;

    // Receiver FSM encoding, kept as plain constants for older tooling.
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage : serial_pkg

// File: rtl/serial_deserializer_sync_fifo.sv
// Small synchronous FIFO built from a read pointer plus an occupancy count.
// When full, a push is still taken if a pop frees the head slot on the same
// edge, so a consumer with i_ready tied high never loses a word.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = PW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;
    logic [CW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    // Status, handshake qualification and the write slot derived from head+count.
    always_comb begin
        empty   = (count == '0);
        full    = (count == CW'(DEPTH));
        do_pop  = pop && !empty;
        do_push = push && (!full || do_pop);
        wr_ptr  = rd_ptr + count[PW-1:0];
        dout    = empty ? '0 : mem[rd_ptr];
    end

    // Storage array; contents are only ever read once written, so no reset.
    always_ff @(posedge i_clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Head pointer and occupancy; a simultaneous push and pop leaves count alone.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule : sync_fifo

// File: rtl/serial_deserializer.sv
// Bit-serial receiver: collects LSB-first frames started by i_sof into
// DATA_WIDTH-bit words and hands them out through a small valid/ready FIFO.
// A new i_sof during a frame aborts it and restarts on that same bit.
module serial_deserializer
    import serial_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_serial,
    input  logic                  i_serial_valid,
    input  logic                  i_sof,
    output logic [DATA_WIDTH-1:0] o_data,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic                  o_busy,
    output logic                  o_frame_err,
    output logic                  o_overflow
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] LAST_POS = CW'(DATA_WIDTH - 1);

    logic [0:0]            state;
    logic [CW-1:0]         bit_cnt;
    logic [DATA_WIDTH-1:0] shift_reg;
    logic                  frame_err_q;
    logic                  overflow_q;
    logic                  frame_done;
    logic                  frame_abort;
    logic [DATA_WIDTH-1:0] push_word;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_empty;
    logic                  fifo_full;

    // Frame completion/abort detection; the finished word includes the bit arriving now.
    always_comb begin
        frame_done  = i_serial_valid && !i_sof && (state == ST_SHIFT) && (bit_cnt == LAST_POS);
        frame_abort = i_serial_valid && i_sof && (state == ST_SHIFT);
        push_word   = shift_reg;
        push_word[DATA_WIDTH-1] = i_serial;
        fifo_push   = frame_done;
        fifo_pop    = !fifo_empty && i_ready;
    end

    // Receive FSM, bit counter and shift register, all advancing only on accepted bits.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state       <= ST_IDLE;
            bit_cnt     <= '0;
            shift_reg   <= '0;
            frame_err_q <= 1'b0;
        end else begin
            frame_err_q <= frame_abort;
            if (i_serial_valid) begin
                if (i_sof) begin
                    shift_reg <= {{(DATA_WIDTH-1){1'b0}}, i_serial};
                    bit_cnt   <= CW'(1);
                    state     <= ST_SHIFT;
                end else if (state == ST_SHIFT) begin
                    shift_reg[bit_cnt] <= i_serial;
                    if (bit_cnt == LAST_POS) begin
                        bit_cnt <= '0;
                        state   <= ST_IDLE;
                    end else begin
                        bit_cnt <= bit_cnt + CW'(1);
                    end
                end
            end
        end
    end

    // Sticky overflow: a finished word found the buffer full with nothing leaving.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            overflow_q <= 1'b0;
        end else if (fifo_push && fifo_full && !fifo_pop) begin
            overflow_q <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH (DATA_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .push      (fifo_push),
        .push_data (push_word),
        .pop       (fifo_pop),
        .dout      (o_data),
        .empty     (fifo_empty),
        .full      (fifo_full)
    );

    // Status outputs are all register-sourced.
    always_comb begin
        o_valid     = !fifo_empty;
        o_busy      = (state == ST_SHIFT);
        o_frame_err = frame_err_q;
        o_overflow  = overflow_q;
    end

endmodule : serial_deserializer

// File: tb/tb_serial_deserializer.sv
// Directed and randomized bench for serial_deserializer. A frame-level model
// (bit list accumulated arithmetically, word queue with a capacity) predicts
// every output after each clock edge.
module tb_serial_deserializer;

    localparam int W = 8;
    localparam int D = 4;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_serial;
    logic         i_serial_valid;
    logic         i_sof;
    logic         i_ready;
    logic [W-1:0] o_data;
    logic         o_valid;
    logic         o_busy;
    logic         o_frame_err;
    logic         o_overflow;

    int vectors     = 0;
    int miscompares = 0;
    int busy_tally  = 0;
    int valid_tally = 0;

    logic [W-1:0] mq[$];
    bit           m_busy;
    int           m_nbits;
    logic [W-1:0] m_word;
    bit           m_err;
    bit           m_ovf;

    serial_deserializer #(
        .DATA_WIDTH (W),
        .FIFO_DEPTH (D)
    ) dut (
        .i_clk          (i_clk),
        .i_rst          (i_rst),
        .i_serial       (i_serial),
        .i_serial_valid (i_serial_valid),
        .i_sof          (i_sof),
        .o_data         (o_data),
        .o_valid        (o_valid),
        .i_ready        (i_ready),
        .o_busy         (o_busy),
        .o_frame_err    (o_frame_err),
        .o_overflow     (o_overflow)
    );

    // Free-running clock.
    always #5 i_clk = ~i_clk;

    task automatic compare(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        compare("o_valid", 32'(o_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            compare("o_data", 32'(o_data), 32'(mq[0]));
        end
        compare("o_busy", 32'(o_busy), 32'(m_busy));
        compare("o_frame_err", 32'(o_frame_err), 32'(m_err));
        compare("o_overflow", 32'(o_overflow), 32'(m_ovf));
        if (o_busy === 1'b1) busy_tally++;
        if (o_valid === 1'b1) valid_tally++;
    endtask

    task automatic applyStimulus(bit ser, bit vld, bit sof, bit rdy, bit rst);
        i_serial       = ser;
        i_serial_valid = vld;
        i_sof          = sof;
        i_ready        = rdy;
        i_rst          = rst;
        if (rst) begin
            mq.delete();
            m_busy  = 0;
            m_nbits = 0;
            m_word  = '0;
            m_err   = 0;
            m_ovf   = 0;
        end else begin
            m_err = 0;
            if (mq.size() != 0 && rdy) void'(mq.pop_front());
            if (vld) begin
                if (sof) begin
                    m_err   = m_busy;
                    m_busy  = 1;
                    m_word  = W'(ser);
                    m_nbits = 1;
                end else if (m_busy) begin
                    m_word  = m_word | (W'(ser) << m_nbits);
                    m_nbits = m_nbits + 1;
                    if (m_nbits == W) begin
                        m_busy = 0;
                        if (mq.size() < D) mq.push_back(m_word);
                        else m_ovf = 1;
                    end
                end
            end
        end
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    task automatic step(bit ser, bit vld, bit sof, bit rdy, bit rst);
        applyStimulus(ser, vld, sof, rdy, rst);
        checkOutput();
    endtask

    task automatic idle(int n, bit rdy);
        for (int k = 0; k < n; k++) step(1'b0, 1'b0, 1'b0, rdy, 1'b0);
    endtask

    task automatic sendFrame(logic [W-1:0] word, int max_gap, bit rdy_body, bit rdy_last);
        logic [W-1:0] w;
        w = word;
        for (int i = 0; i < W; i++) begin
            int gaps;
            gaps = (max_gap > 0) ? int'($urandom_range(max_gap, 0)) : 0;
            for (int g = 0; g < gaps; g++) step(1'($urandom), 1'b0, 1'($urandom), rdy_body, 1'b0);
            step(w[i], 1'b1, i == 0, (i == W - 1) ? rdy_last : rdy_body, 1'b0);
        end
    endtask

    initial begin
        i_rst = 1'b1; i_serial = 1'b0; i_serial_valid = 1'b0; i_sof = 1'b0; i_ready = 1'b0;

        $display("[TB] reset");
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        compare("o_data_after_reset", 32'(o_data), 32'h0);

        $display("[TB] single frame 0x55");
        busy_tally = 0; valid_tally = 0;
        sendFrame(8'h55, 0, 1'b1, 1'b1);
        idle(3, 1'b1);
        compare("busy_cycles_55", 32'(busy_tally), 32'd7);
        compare("valid_cycles_55", 32'(valid_tally), 32'd1);

        $display("[TB] back-to-back frames with gaps");
        sendFrame(8'hC3, 3, 1'b1, 1'b1);
        sendFrame(8'h0F, 3, 1'b1, 1'b1);
        idle(3, 1'b1);

        $display("[TB] aborted partial frame");
        for (int i = 0; i < 5; i++) step(1'($urandom), 1'b1, i == 0, 1'b1, 1'b0);
        sendFrame(8'hA5, 0, 1'b1, 1'b1);
        idle(3, 1'b1);

        $display("[TB] overflow with consumer stalled");
        for (int f = 1; f <= 5; f++) sendFrame(W'(f), 1, 1'b0, 1'b0);
        idle(3, 1'b0);
        compare("overflow_set", 32'(o_overflow), 32'h1);
        idle(7, 1'b1);

        $display("[TB] full buffer with pop on last bit");
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        for (int f = 1; f <= 4; f++) sendFrame(W'(f), 0, 1'b0, 1'b0);
        sendFrame(8'h05, 0, 1'b0, 1'b1);
        compare("no_overflow_on_pop", 32'(o_overflow), 32'h0);
        idle(6, 1'b1);

        $display("[TB] reset mid-frame with buffered words");
        sendFrame(8'h11, 0, 1'b0, 1'b0);
        sendFrame(8'h22, 0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1, i == 0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
        compare("valid_after_midreset", 32'(o_valid), 32'h0);
        compare("busy_after_midreset", 32'(o_busy), 32'h0);
        sendFrame(8'h3C, 0, 1'b1, 1'b1);
        idle(3, 1'b1);

        $display("[TB] randomized traffic");
        for (int c = 0; c < 600; c++) begin
            bit vld;
            bit sof;
            bit rdy;
            bit rst;
            vld = ($urandom_range(3, 0) != 0);
            sof = ($urandom_range(11, 0) == 0);
            rdy = ($urandom_range(2, 0) != 0);
            rst = ($urandom_range(249, 0) == 0);
            step(1'($urandom), vld, sof, rdy, rst);
        end
        idle(8, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule : tb_serial_deserializer
